// File: rtl/mem_access_stage_if.sv
// Memory-side bus of the memory-access stage: registered request, one-cycle
// ready pulse with read data in the same cycle.
interface mem_access_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ready, rdata);
  modport slave  (input  req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU ops pass through in one cycle, loads and
// stores hold execute in BUSY until mem.ready or a bounded timeout abort.
module mem_access_stage #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                REG_W    = 5,
  parameter int                CTRL_W   = 4,
  parameter logic [CTRL_W-1:0] LOAD_OP  = CTRL_W'(4'b1100),
  parameter logic [CTRL_W-1:0] STORE_OP = CTRL_W'(4'b1110),
  parameter int                TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid_ex,
  input  logic [CTRL_W-1:0] i_control_ex,
  input  logic [DATA_W-1:0] i_result_ex,
  input  logic [DATA_W-1:0] i_reg_data_ex,
  input  logic [REG_W-1:0]  i_dest_reg_index_ex,
  input  logic              i_dest_reg_write_en_ex,
  output logic              o_stall_ma,
  mem_access_stage_if.master mem,
  output logic              o_valid_ma,
  output logic [CTRL_W-1:0] o_control_ma,
  output logic [DATA_W-1:0] o_result_ma,
  output logic [DATA_W-1:0] o_data_ma,
  output logic [REG_W-1:0]  o_dest_reg_index_ma,
  output logic              o_dest_reg_write_en_ma,
  output logic              o_err_ma
);
  // TIMEOUT = 0 still needs a 1-bit counter; the abort compare is disabled.
  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               TO_EN    = (TIMEOUT > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] res;
    logic [REG_W-1:0]  idx;
    logic              wen;
    logic              is_load;
  } hold_t;

  state_t          r_state;
  hold_t           r_hold;
  logic [CNT_W-1:0] r_cnt;

  logic w_is_load, w_is_store, w_is_mem, w_timeout;

  assign w_is_load  = (i_control_ex == LOAD_OP);
  assign w_is_store = (i_control_ex == STORE_OP);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_timeout  = TO_EN && (r_cnt == CNT_LAST);
  assign o_stall_ma = (r_state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state                <= IDLE;
      r_hold                 <= '0;
      r_cnt                  <= '0;
      mem.req                <= 1'b0;
      mem.we                 <= 1'b0;
      mem.addr               <= '0;
      mem.wdata              <= '0;
      o_valid_ma             <= 1'b0;
      o_control_ma           <= '0;
      o_result_ma            <= '0;
      o_data_ma              <= '0;
      o_dest_reg_index_ma    <= '0;
      o_dest_reg_write_en_ma <= 1'b0;
      o_err_ma               <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!i_valid_ex) begin
            o_valid_ma <= 1'b0;
          end else if (w_is_mem) begin
            r_hold    <= '{ctrl: i_control_ex, res: i_result_ex, idx: i_dest_reg_index_ex,
                           wen: i_dest_reg_write_en_ex, is_load: w_is_load};
            mem.req   <= 1'b1;
            mem.we    <= w_is_store;
            mem.addr  <= i_result_ex[ADDR_W-1:0];
            mem.wdata <= w_is_store ? i_reg_data_ex : '0;
            o_valid_ma <= 1'b0;
            r_cnt     <= '0;
            r_state   <= BUSY;
          end else begin
            o_valid_ma             <= 1'b1;
            o_control_ma           <= i_control_ex;
            o_result_ma            <= i_result_ex;
            o_dest_reg_index_ma    <= i_dest_reg_index_ex;
            o_dest_reg_write_en_ma <= i_dest_reg_write_en_ex;
            o_data_ma              <= '0;
            o_err_ma               <= 1'b0;
          end
        end
        BUSY: begin
          // Ready has priority over a coinciding timeout.
          if (mem.ready || w_timeout) begin
            mem.req                <= 1'b0;
            mem.we                 <= 1'b0;
            r_state                <= IDLE;
            o_valid_ma             <= 1'b1;
            o_control_ma           <= r_hold.ctrl;
            o_result_ma            <= r_hold.res;
            o_dest_reg_index_ma    <= r_hold.idx;
            o_dest_reg_write_en_ma <= mem.ready ? r_hold.wen : 1'b0;
            o_data_ma              <= (mem.ready && r_hold.is_load) ? mem.rdata : '0;
            o_err_ma               <= !mem.ready;
          end else begin
            o_valid_ma <= 1'b0;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage between execute and writeback. Replaces the single-cycle combinational memory path with a registered request/ready handshake to a variable-latency data memory. Stalls execute while a load or store is outstanding and aborts hung accesses with a bounded timeout. Non-memory instructions pass through to writeback in one cycle.

## Interface
Parameters:
- DATA_W, 16, data and result width
- ADDR_W, 16, memory address width; taken from result_ex[ADDR_W-1:0]
- REG_W, 5, destination register index width
- CTRL_W, 4, control/opcode width
- LOAD_OP, 4'b1100, control code for a load
- STORE_OP, 4'b1110, control code for a store
- TIMEOUT, 64, maximum BUSY cycles before abort; 0 disables the timeout

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_ex  in  1  execute presents an instruction
- control_ex  in  CTRL_W  opcode
- result_ex  in  DATA_W  ALU result; memory address for loads and stores
- reg_data_ex  in  DATA_W  store data
- dest_reg_index_ex  in  REG_W  destination register
- dest_reg_write_en_ex  in  1  register write enable
- stall_ma  out  1  execute must hold its outputs
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ready  in  1  one-cycle completion pulse; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  load data
- valid_ma, control_ma, result_ma, data_ma, dest_reg_index_ma, dest_reg_write_en_ma  out  1/CTRL_W/DATA_W/DATA_W/REG_W/1  registered to writeback
- err_ma  out  1  the completed access timed out

## Operation
- Two states: IDLE and BUSY. stall_ma = (state == BUSY), driven combinationally from the state register only.
- IDLE, valid_ex = 0:
  - valid_ma <= 0.
  - Payload outputs hold their previous values.
- IDLE, valid_ex = 1, non-memory opcode:
  - valid_ma <= 1; control, result, index and write-enable are copied.
  - data_ma <= 0, err_ma <= 0.
- IDLE, valid_ex = 1, LOAD_OP or STORE_OP:
  - Capture control, result, index and write-enable into holding registers.
  - mem_req <= 1, mem_addr <= result_ex, mem_we <= (STORE_OP), mem_wdata <= reg_data_ex (store only, otherwise 0).
  - valid_ma <= 0; timeout counter <= 0; state <= BUSY.
- BUSY:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - The counter increments every cycle in which mem_ready = 0.
- BUSY, mem_ready = 1 (completion):
  - mem_req <= 0, mem_we <= 0; state <= IDLE.
  - valid_ma <= 1; the held fields are driven to the _ma outputs.
  - data_ma <= mem_rdata for a load, 0 for a store; err_ma <= 0.
- BUSY, counter == TIMEOUT-1 with mem_ready = 0 (TIMEOUT > 0):
  - Abort: mem_req <= 0; state <= IDLE; valid_ma <= 1; err_ma <= 1.
  - dest_reg_write_en_ma <= 0; data_ma <= 0.
- mem_ready in IDLE is ignored; it does not change outputs or state.
- If mem_ready and the timeout coincide, mem_ready wins (normal completion, err_ma = 0).
- Counter width is $clog2(TIMEOUT+1) and saturates; it never wraps.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE; stall_ma = 0.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - All _ma outputs = 0, err_ma = 0, counter = 0.
- Reset during BUSY drops mem_req immediately; the outstanding access is abandoned with no writeback.
- Non-memory instruction: accepted at edge N, visible on _ma after edge N; throughput 1 per cycle.
- Memory instruction:
  - Accepted at edge N; mem_req is high from edge N.
  - If mem_ready is first high in cycle N+k (k ≥ 1), completion happens at edge N+k.
  - stall_ma is high for cycles N+1 through N+k.
  - The instruction held in execute is accepted at edge N+k+1, so every memory op is followed by one bubble.
- Minimum memory-op occupancy is 2 cycles (k = 1).
- Timeout abort: the abort edge is N+TIMEOUT.
- valid_ma is 0 on every cycle in which the stage produced no completion.

## Test plan
- Reset: hold rst_n low mid-BUSY -> mem_req = 0 and stall_ma = 0 asynchronously; all outputs 0.
- Three back-to-back ALU ops (result 16'h0011/0022/0033) -> valid_ma high for 3 consecutive cycles; result_ma matches each value one cycle later; stall_ma never asserted.
- LOAD with address 16'h0040, mem_ready after 3 cycles carrying mem_rdata = 16'hBEEF:
  - mem_addr = 16'h0040 and mem_we = 0 throughout.
  - stall_ma high for 3 cycles.
  - data_ma = 16'hBEEF with valid_ma = 1 for one cycle; the next instruction is accepted after one bubble.
- STORE with address 16'h0010, reg_data 16'h1234, mem_ready on the first BUSY cycle -> mem_we = 1 and mem_wdata = 16'h1234 for one cycle; data_ma = 0; total occupancy 2 cycles.
- TIMEOUT = 4, LOAD with no mem_ready:
  - Abort at edge N+4: err_ma = 1, dest_reg_write_en_ma = 0, mem_req drops.
  - A late mem_ready pulse in IDLE is ignored.
- TIMEOUT = 4, mem_ready arrives exactly on the abort cycle -> normal completion with err_ma = 0 and data captured.
